// File: rtl/comet_io_pkg.sv
// comet_io_pkg: shared I/O address map, status bit indices and UART TX state type (UART_PARITY_EN adds PARITY)
package comet_io_pkg;
  localparam logic [15:0] UART_DATA_ADDR = 16'hFF00;
  localparam logic [15:0] UART_STAT_ADDR = 16'hFF01;
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_OVF = 2;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_tx_state_t;
endpackage

// File: rtl/comet_sync_fifo.sv
// comet_sync_fifo: show-ahead synchronous FIFO with wrap-bit pointers for full/empty detection
module comet_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign rd_data = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/comet_uart_tx_port.sv
// comet_uart_tx_port: memory-mapped buffered 8N1 UART transmitter with status register (UART_PARITY_EN adds even parity)
module comet_uart_tx_port
  import comet_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = UART_DATA_ADDR,
  parameter int CLK_DIV = 69,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        we,
  input  logic [15:0] waddr,
  input  logic [15:0] wdata,
  input  logic        re,
  input  logic [15:0] raddr,
  output logic [15:0] rdata,
  output logic        rsel,
  output logic        tx,
  output logic        busy
);
  localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);
  uart_tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] sh, sh_n, head;
  logic [2:0] stat;
  logic data_hit, stat_wr, stat_rd, pop, full, empty, ovf, tick;
  logic unused;
  assign unused = ^wdata[15:8];
  assign data_hit = we && waddr == BASE_ADDR;
  assign stat_wr = we && waddr == STAT_ADDR;
  assign stat_rd = re && raddr == STAT_ADDR;
  assign tick = cnt == '0;
  comet_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(mclk),
    .rst(rst),
    .push(data_hit),
    .wr_data(wdata[7:0]),
    .pop(pop),
    .rd_data(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_n = state;
    cnt_n = tick ? RELOAD : cnt - 1'b1;
    bit_n = bit_idx;
    sh_n = sh;
    pop = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!empty) begin
          pop = 1'b1;
          sh_n = head;
          cnt_n = RELOAD;
          state_n = START;
        end
      end
      START: if (tick) state_n = DATA;
      DATA: if (tick) begin
        bit_n = bit_idx + 3'd1;
`ifdef UART_PARITY_EN
        if (bit_idx == 3'd7) state_n = PARITY;
`else
        if (bit_idx == 3'd7) state_n = STOP;
`endif
      end
`ifdef UART_PARITY_EN
      PARITY: if (tick) state_n = STOP;
`endif
      STOP: if (tick) begin
        pop = !empty;
        sh_n = empty ? sh : head;
        state_n = empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    stat = '0;
    stat[STAT_EMPTY] = empty && state == IDLE;
    stat[STAT_FULL] = full;
    stat[STAT_OVF] = ovf;
  end
  always_ff @(posedge mclk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      ovf <= 1'b0;
      tx <= 1'b1;
      busy <= 1'b0;
      rsel <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      sh <= sh_n;
      ovf <= (data_hit && full) ? 1'b1 : (stat_wr && wdata[STAT_OVF]) ? 1'b0 : ovf;
`ifdef UART_PARITY_EN
      tx <= state == START ? 1'b0 : state == DATA ? sh[bit_idx] : state == PARITY ? ^sh : 1'b1;
`else
      tx <= state == START ? 1'b0 : state == DATA ? sh[bit_idx] : 1'b1;
`endif
      busy <= state != IDLE || !empty;
      rsel <= stat_rd;
      rdata <= stat_rd ? {13'b0, stat} : 16'h0000;
    end
  end
endmodule
